// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//  Shared definitions for the fetch sequencer and the instruction memory it
//  drives: address/instruction widths, the HALT encoding, and the fetch FSM
//  state encoding.
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] HALT_INST_ENC = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//  Fetch sequencer for a combinational-read instruction memory. Owns the PC,
//  presents it on imem_pc, and registers the returned word into a valid/ready
//  stage for decode. Handles decode backpressure, branch redirect, HALT
//  detection (with resume via redirect), and counts accepted fetches.
//
// Ports
//  clk, rst_n        clock, asynchronous active-low reset
//  imem_pc           address to instruction memory (always pc_q)
//  imem_instruction  word returned in the same cycle for imem_pc
//  branch_taken      redirect strobe; also resumes from HALTED
//  branch_target     redirect address
//  if_valid          fetch stage holds a live instruction
//  if_ready          decode accepts if_instruction this cycle
//  if_instruction    fetched word
//  if_pc             address of if_instruction
//  halted            HALTED and fetch stage drained
//  fetch_count       accepted fetches (if_valid & if_ready), wraps at 2^32
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = ADDR_W,
  parameter int                    INST_WIDTH   = INST_W,
  parameter int                    IMEMORY_SIZE = 1024,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [INST_WIDTH-1:0] HALT_INST    = HALT_INST_ENC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_pc,
  input  logic [INST_WIDTH-1:0] imem_instruction,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(IMEMORY_SIZE - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_seq;
  logic                  vld_q, vld_d;
  logic [INST_WIDTH-1:0] inst_q;
  logic [ADDR_WIDTH-1:0] ipc_q;
  logic [31:0]           cnt_q;
  logic                  load, accept, latch;

  assign load   = !vld_q || if_ready;
  assign accept = vld_q && if_ready;
  // Sequential successor: natural mod-2^ADDR_WIDTH increment, then wrap at
  // the end of the memory.
  assign pc_seq = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_WIDTH'(1);

  // Next-state: redirect beats everything; a HALT word is latched like any
  // other but freezes the PC on its own address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    latch   = 1'b0;
    if (branch_taken) begin
      pc_d    = branch_target;
      vld_d   = 1'b0;
      state_d = FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (load) begin
            latch = 1'b1;
            vld_d = 1'b1;
            if (imem_instruction == HALT_INST) state_d = FETCH_HALTED;
            else                               pc_d    = pc_seq;
          end
        end
        FETCH_HALTED: begin
          if (accept) vld_d = 1'b0;
        end
        default: state_d = FETCH_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      inst_q <= '0;
      ipc_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (latch) begin
        inst_q <= imem_instruction;
        ipc_q  <= pc_q;
      end
    end
  end

  // Counts acceptances even in a redirect cycle: decode did take that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 32'd1;
  end

  assign imem_pc        = pc_q;
  assign if_valid       = vld_q;
  assign if_instruction = inst_q;
  assign if_pc          = ipc_q;
  assign halted         = (state_q == FETCH_HALTED) && !vld_q;
  assign fetch_count    = cnt_q;

endmodule
